dut_keypad_scan: RTL and testbench

- Parametrised, self-scanning matrix keypad controller for the calculator datapath.
- Drives rows one-hot, samples synchronised column inputs and debounces whole scan frames.
- Emits one decoded key event per press over a valid/ready handshake to the calculator control FSM.
- Flags multi-key presses and dropped events.

---
 rtl/dut_keypad_scan.sv | 239 +++++++++++++++++++++++
 tb/tb_dut_keypad_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dut_keypad_scan.sv
// Self-scanning matrix keypad controller: row drive, column sync, frame debounce, key events.
// Optional auto-repeat of held keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module dut_keypad_scan #(
  parameter int unsigned KEY_ROW     = 4,
  parameter int unsigned KEY_COL     = 4,
  parameter int unsigned KEY_W       = 4,
  parameter int unsigned SCAN_DIV    = 16,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned REPEAT_DLY  = 32,
  parameter int unsigned REPEAT_RATE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_COL-1:0] col_in,
  output logic [KEY_ROW-1:0] row_drv,
  output logic [KEY_W-1:0]   key,
  output logic               valid,
  input  logic               ready,
  output logic               multi,
  output logic               ovf
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned ROW_W = $clog2(KEY_ROW);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} db_state_e;

  logic [KEY_COL-1:0] col_s1_q, col_s2_q;
  logic [DIV_W-1:0]   div_q;
  logic [ROW_W-1:0]   row_q;
  logic [KEY_ROW-1:0] row_drv_q;
  logic [1:0]         acc_n_q;
  logic [KEY_W-1:0]   acc_code_q;

  db_state_e          state_q, state_d;
  logic [KEY_W-1:0]   cand_q, cand_d;
  logic [DB_W-1:0]    cnt_q, cnt_d;

  logic [KEY_W-1:0]   key_q;
  logic               valid_q, multi_q, ovf_q;

  logic               sample, frame_end;
  logic [1:0]         tot_n;
  logic [KEY_W-1:0]   tot_code;
  logic               f_single, f_multi, match;
  logic               press_evt, rep_evt, evt;
  logic [KEY_W-1:0]   evt_code;

  assign sample    = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end = sample && (row_q == ROW_W'(KEY_ROW - 1));

  // Running key count saturates at 2: only none/one/many matters per frame.
  always_comb begin
    tot_n    = acc_n_q;
    tot_code = acc_code_q;
    for (int i = 0; i < int'(KEY_COL); i++) begin
      if (col_s2_q[i]) begin
        if (tot_n == 2'd0) tot_code = KEY_W'(int'(row_q) * int'(KEY_COL) + i);
        if (tot_n != 2'd2) tot_n = tot_n + 2'd1;
      end
    end
  end

  assign f_single = (tot_n == 2'd1);
  assign f_multi  = (tot_n == 2'd2);
  assign match    = f_single && (tot_code == cand_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q   <= '0;
      col_s2_q   <= '0;
      div_q      <= '0;
      row_q      <= '0;
      row_drv_q  <= KEY_ROW'(1);
      acc_n_q    <= '0;
      acc_code_q <= '0;
      multi_q    <= 1'b0;
    end else begin
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
      if (sample) begin
        div_q     <= '0;
        row_drv_q <= {row_drv_q[KEY_ROW-2:0], row_drv_q[KEY_ROW-1]};
        if (frame_end) begin
          row_q      <= '0;
          acc_n_q    <= '0;
          acc_code_q <= '0;
          multi_q    <= f_multi;
        end else begin
          row_q      <= row_q + ROW_W'(1);
          acc_n_q    <= tot_n;
          acc_code_q <= tot_code;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (f_single) begin
            cand_d = tot_code;
            cnt_d  = DB_W'(1);
            if (DEBOUNCE == 1) begin
              state_d   = StHeld;
              press_evt = 1'b1;
            end else begin
              state_d = StPressDb;
            end
          end
        end
        StPressDb: begin
          if (match) begin
            cnt_d = cnt_q + DB_W'(1);
            if (cnt_d == DB_W'(DEBOUNCE)) begin
              state_d   = StHeld;
              press_evt = 1'b1;
            end
          end else if (f_single) begin
            cand_d = tot_code;
            cnt_d  = DB_W'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          if (!match) begin
            cnt_d   = DB_W'(1);
            state_d = (DEBOUNCE == 1) ? StIdle : StRelDb;
          end
        end
        StRelDb: begin
          if (match) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
            if (cnt_d == DB_W'(DEBOUNCE)) begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RP_W    = $clog2(REP_MAX + 1);

  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_phase_q, rep_phase_d;

  // Counter only runs across consecutive held frames; any other frame rearms the initial delay.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_evt     = 1'b0;
    if (frame_end) begin
      if (state_q == StHeld && match) begin
        rep_cnt_d = rep_cnt_q + RP_W'(1);
        if ((!rep_phase_q && rep_cnt_d == RP_W'(REPEAT_DLY)) ||
            (rep_phase_q && rep_cnt_d == RP_W'(REPEAT_RATE))) begin
          rep_evt     = 1'b1;
          rep_cnt_d   = '0;
          rep_phase_d = 1'b1;
        end
      end else begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  logic unused_rep_params;
  assign unused_rep_params = ^{32'(REPEAT_DLY), 32'(REPEAT_RATE)};
  assign rep_evt           = 1'b0;
`endif

  assign evt      = press_evt || rep_evt;
  assign evt_code = cand_d;

  // A stalled consumer keeps the old event; the new one is lost and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (evt) begin
      if (valid_q && !ready) begin
        ovf_q <= 1'b1;
      end else begin
        key_q   <= evt_code;
        valid_q <= 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign row_drv = row_drv_q;
  assign key     = key_q;
  assign valid   = valid_q;
  assign multi   = multi_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_dut_keypad_scan.sv
// Scoreboard bench for dut_keypad_scan: a keypad matrix model, expected key codes queued at press.
module tb_dut_keypad_scan;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_drv;
  logic [3:0]  key;
  logic        valid;
  logic        ready;
  logic        multi;
  logic        ovf;
  logic [15:0] keys;

  int n_tests = 0;
  int n_fail  = 0;
  int evt_cnt = 0;
  int base;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  dut_keypad_scan #(
    .KEY_ROW(4), .KEY_COL(4), .KEY_W(4), .SCAN_DIV(4), .DEBOUNCE(3),
    .REPEAT_DLY(4), .REPEAT_RATE(2)
  ) u_dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_drv(row_drv), .key(key),
    .valid(valid), .ready(ready), .multi(multi), .ovf(ovf)
  );

  // Pressed switch connects its driven row to its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_drv[r] && keys[r*4+c]) col_in[c] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      evt_cnt++;
      if (exp_q.size() == 0) check("extra_evt", 32'd1, 32'd0);
      else check("evt_key", 32'(key), 32'(exp_q.pop_front()));
    end
  end

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic sync_frame();
    int n = 0;
    while (row_drv !== 4'b1000 && n < 100) begin @(posedge clk); #1; n++; end
    while (row_drv !== 4'b0001 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("sync_frame", 32'(n), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int exp_cyc);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (valid !== 1'b1 && n < 400);
    check(tag, 32'(n), 32'(exp_cyc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    ready = 1'b1;
    keys  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", 32'(row_drv), 32'd1);
    check("rst_key", 32'(key), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_multi", 32'(multi), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      repeat (4) @(posedge clk);
      #1;
      check("row_seq", 32'(row_drv), 32'(1 << (i % 4)));
    end
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_multi", 32'(multi), 32'd0);

    // Single press: row 2 col 1 held 10 frames.
    sync_frame();
    base = evt_cnt;
    keys = 16'(1 << 9);
    exp_q.push_back(4'd9);
    wait_valid("k9_lat", 3 * FRAME);
    frames(7);
    keys = '0;
    frames(5);
    check("k9_count", 32'(evt_cnt - base), 32'd1);

    // Highest code.
    sync_frame();
    base = evt_cnt;
    keys = 16'(1 << 15);
    exp_q.push_back(4'd15);
    wait_valid("k15_lat", 3 * FRAME);
    frames(2);
    keys = '0;
    frames(5);
    check("k15_count", 32'(evt_cnt - base), 32'd1);

    // Bounce: two good frames, one empty, then a clean press.
    sync_frame();
    base = evt_cnt;
    keys = 16'(1 << 5);
    frames(2);
    keys = '0;
    frames(1);
    check("bounce_valid", 32'(valid), 32'd0);
    check("bounce_count", 32'(evt_cnt - base), 32'd0);
    keys = 16'(1 << 5);
    exp_q.push_back(4'd5);
    wait_valid("k5_lat", 3 * FRAME);
    frames(2);
    keys = '0;
    frames(5);
    check("k5_count", 32'(evt_cnt - base), 32'd1);

    // Two keys together: multi flagged, no event until one is released.
    sync_frame();
    base = evt_cnt;
    keys = 16'h8001;
    frames(1);
    check("multi_set", 32'(multi), 32'd1);
    frames(4);
    check("multi_hold", 32'(multi), 32'd1);
    check("multi_noevt", 32'(evt_cnt - base), 32'd0);
    keys = 16'h0001;
    exp_q.push_back(4'd0);
    wait_valid("k0_lat", 3 * FRAME);
    check("multi_clr", 32'(multi), 32'd0);
    frames(2);
    keys = '0;
    frames(5);
    check("k0_count", 32'(evt_cnt - base), 32'd1);

    // Stalled consumer: second press is dropped and flagged.
    sync_frame();
    ready = 1'b0;
    keys  = 16'(1 << 3);
    exp_q.push_back(4'd3);
    frames(4);
    keys = '0;
    frames(4);
    keys = 16'(1 << 7);
    frames(4);
    keys = '0;
    frames(4);
    check("stall_valid", 32'(valid), 32'd1);
    check("stall_key", 32'(key), 32'd3);
    check("stall_ovf", 32'(ovf), 32'd1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_valid", 32'(valid), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Held key: auto-repeat when enabled, otherwise a single event.
    sync_frame();
    base = evt_cnt;
    keys = 16'(1 << 12);
    exp_q.push_back(4'd12);
    wait_valid("k12_lat", 3 * FRAME);
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(4'd12);
    wait_valid("rep_dly", 4 * FRAME);
    for (int i = 0; i < 3; i++) wait_valid("rep_rate", 2 * FRAME);
    keys = '0;
    frames(5);
    check("k12_count", 32'(evt_cnt - base), 32'd5);
`else
    frames(10);
    keys = '0;
    frames(5);
    check("k12_count", 32'(evt_cnt - base), 32'd1);
`endif

    // Reset while an event waits for the consumer discards it.
    sync_frame();
    ready = 1'b0;
    keys  = 16'(1 << 1);
    frames(4);
    check("pend_valid", 32'(valid), 32'd1);
    check("pend_key", 32'(key), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    keys = '0;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_key", 32'(key), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_row", 32'(row_drv), 32'd1);
    ready = 1'b1;
    frames(6);
    check("post_rst_valid", 32'(valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
